// File: rtl/cache_repl_pkg.sv
// Shared types and size derivations for the multi-port cache replacement-state unit.
package cache_repl_pkg;

  typedef enum logic [1:0] {
    FIFO   = 2'd0,
    PLRU   = 2'd1,
    RROBIN = 2'd2
  } repl_policy_e;

  typedef enum logic [0:0] {
    StInit  = 1'b0,
    StReady = 1'b1
  } init_state_e;

  function automatic int unsigned calc_lines(int unsigned cache_size, int unsigned line_size,
                                             int unsigned num_banks, int unsigned num_ways);
    int unsigned lines;
    lines = cache_size / (line_size * num_banks * num_ways);
    return (lines > 0) ? lines : 1;
  endfunction

  function automatic int unsigned calc_lsb(int unsigned lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  function automatic int unsigned calc_wsw(int unsigned num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/cache_repl_mp_if.sv
// Hit-update and victim request/response bundle between the pipeline and the replacement unit.
interface cache_repl_mp_if #(
  parameter int unsigned NumLookups = 2,
  parameter int unsigned Lsb        = 4,
  parameter int unsigned Wsw        = 2
);
  logic [NumLookups-1:0]          lookup_valid;
  logic [NumLookups-1:0][Lsb-1:0] lookup_line;
  logic [NumLookups-1:0][Wsw-1:0] lookup_way;
  logic                           repl_valid;
  logic                           repl_ready;
  logic [Lsb-1:0]                 repl_line;
  logic                           repl_rsp_valid;
  logic [Wsw-1:0]                 repl_way;

  modport master (
    output lookup_valid, lookup_line, lookup_way, repl_valid, repl_line,
    input  repl_ready, repl_rsp_valid, repl_way
  );

  modport slave (
    input  lookup_valid, lookup_line, lookup_way, repl_valid, repl_line,
    output repl_ready, repl_rsp_valid, repl_way
  );
endinterface

// File: rtl/cache_repl_plru_tree.sv
// Combinational PLRU helper: hit way -> (data, mask) tree update, and tree bits -> victim way.
module cache_repl_plru_tree
  import cache_repl_pkg::*;
#(
  parameter int unsigned NumWays  = 4,
  parameter int unsigned Wsw      = 2,
  parameter int unsigned TreeBits = 3
) (
  input  logic [Wsw-1:0]      way_i,
  input  logic [TreeBits-1:0] bits_i,
  output logic [TreeBits-1:0] data_o,
  output logic [TreeBits-1:0] mask_o,
  output logic [Wsw-1:0]      victim_o
);
  localparam int unsigned Levels = (NumWays > 1) ? $clog2(NumWays) : 0;
  localparam int unsigned NodeW  = (TreeBits > 1) ? $clog2(TreeBits) : 1;

  // Each node on the hit path points away from the hit way: bit=1 means "go right".
  always_comb begin
    int unsigned   node;
    logic          b;
    logic [Wsw-1:0] sh;
    data_o = '0;
    mask_o = '0;
    node   = 0;
    b      = 1'b0;
    sh     = '0;
    for (int unsigned lvl = 0; lvl < Levels; lvl++) begin
      sh                  = way_i >> (Levels - 1 - lvl);
      b                   = sh[0];
      mask_o[NodeW'(node)] = 1'b1;
      data_o[NodeW'(node)] = ~b;
      node                = 2 * node + 1 + 32'(b);
    end
  end

  always_comb begin
    int unsigned vnode;
    logic        vb;
    victim_o = '0;
    vnode    = 0;
    vb       = 1'b0;
    for (int unsigned lvl = 0; lvl < Levels; lvl++) begin
      vb       = bits_i[NodeW'(vnode)];
      victim_o = (victim_o << 1) | Wsw'(vb);
      vnode    = 2 * vnode + 1 + 32'(vb);
    end
  end

endmodule

// File: rtl/cache_repl_mp.sv
// Multi-port replacement-state unit for one cache bank: init sweep, per-set PLRU/FIFO state or a
// global round-robin counter, port-ordered hit merge and a one-cycle victim response register.
module cache_repl_mp
  import cache_repl_pkg::*;
#(
  parameter int unsigned  CACHE_SIZE  = 1024,
  parameter int unsigned  LINE_SIZE   = 64,
  parameter int unsigned  NUM_BANKS   = 1,
  parameter int unsigned  NUM_WAYS    = 4,
  parameter int unsigned  NUM_LOOKUPS = 2,
  parameter repl_policy_e REPL_POLICY = PLRU
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush,
  output logic           init_done,
  cache_repl_mp_if.slave repl_if
);
  localparam int unsigned Lines    = calc_lines(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS);
  localparam int unsigned Lsb      = calc_lsb(Lines);
  localparam int unsigned Wsw      = calc_wsw(NUM_WAYS);
  localparam int unsigned TreeBits = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
  localparam logic [Lsb-1:0] LastLine = Lsb'(Lines - 1);
  localparam logic [Wsw-1:0] LastWay  = Wsw'(NUM_WAYS - 1);

  init_state_e    state_q, state_d;
  logic [Lsb-1:0] cnt_q, cnt_d;
  logic           sweep_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == LastLine) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (flush) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    init_done = (state_q == StReady);
    sweep_we  = (state_q == StInit) && !flush;
  end

  logic req_accept;
  assign repl_if.repl_ready = init_done & ~stall;
  assign req_accept         = repl_if.repl_valid & repl_if.repl_ready;

  logic [TreeBits-1:0] plru_q [Lines];
  logic [TreeBits-1:0] plru_d [Lines];
  logic [Wsw-1:0]      fifo_q [Lines];
  logic [Wsw-1:0]      fifo_d [Lines];

  logic [NUM_LOOKUPS-1:0][TreeBits-1:0] upd_data, upd_mask;
  logic [NUM_LOOKUPS-1:0][Wsw-1:0]      unused_lk_victim;
  logic [TreeBits-1:0]                  unused_enc_data, unused_enc_mask;
  logic [Wsw-1:0]                       plru_victim;

  for (genvar p = 0; p < NUM_LOOKUPS; p++) begin : g_lk
    cache_repl_plru_tree #(
      .NumWays (NUM_WAYS),
      .Wsw     (Wsw),
      .TreeBits(TreeBits)
    ) u_upd (
      .way_i   (repl_if.lookup_way[p]),
      .bits_i  ('0),
      .data_o  (upd_data[p]),
      .mask_o  (upd_mask[p]),
      .victim_o(unused_lk_victim[p])
    );
  end

  cache_repl_plru_tree #(
    .NumWays (NUM_WAYS),
    .Wsw     (Wsw),
    .TreeBits(TreeBits)
  ) u_enc (
    .way_i   ('0),
    .bits_i  (plru_q[repl_if.repl_line]),
    .data_o  (unused_enc_data),
    .mask_o  (unused_enc_mask),
    .victim_o(plru_victim)
  );

  always_ff @(posedge clk) begin
    plru_q <= plru_d;
    fifo_q <= fifo_d;
  end

  // Ports applied in index order so the highest port wins on overlapping tree bits.
  always_comb begin
    plru_d = plru_q;
    fifo_d = fifo_q;
    if (sweep_we) begin
      plru_d[cnt_q] = '0;
      fifo_d[cnt_q] = '0;
    end else if (init_done) begin
      if (REPL_POLICY == PLRU) begin
        for (int p = 0; p < NUM_LOOKUPS; p++) begin
          if (repl_if.lookup_valid[p]) begin
            plru_d[repl_if.lookup_line[p]] = (plru_d[repl_if.lookup_line[p]] & ~upd_mask[p]) |
                                             (upd_data[p] & upd_mask[p]);
          end
        end
      end
      if ((REPL_POLICY == FIFO) && req_accept) begin
        fifo_d[repl_if.repl_line] = (fifo_q[repl_if.repl_line] == LastWay) ? '0 :
                                    fifo_q[repl_if.repl_line] + 1'b1;
      end
    end
  end

  logic [Wsw-1:0] rr_q, rr_d;
  logic [Wsw-1:0] victim;
  logic           rsp_valid_q, rsp_valid_d;
  logic [Wsw-1:0] way_q, way_d;

  always_comb begin
    victim = '0;
    if (NUM_WAYS > 1) begin
      case (REPL_POLICY)
        FIFO:    victim = fifo_q[repl_if.repl_line];
        PLRU:    victim = plru_victim;
        RROBIN:  victim = rr_q;
        default: victim = '0;
      endcase
    end
  end

  always_comb begin
    rr_d        = rr_q;
    rsp_valid_d = rsp_valid_q;
    way_d       = way_q;
    if (init_done && !stall) begin
      rr_d = (rr_q == LastWay) ? '0 : rr_q + 1'b1;
    end
    if (!stall) begin
      rsp_valid_d = req_accept;
      if (req_accept) begin
        way_d = victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      way_q       <= '0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      way_q       <= way_d;
    end
  end

  assign repl_if.repl_rsp_valid = rsp_valid_q;
  assign repl_if.repl_way       = way_q;

endmodule

// File: tb/tb_cache_repl_mp.sv
// Bench for cache_repl_mp: FIFO, PLRU and RROBIN instances share stimulus and are checked
// against a behavioural model of the replacement rules.
module tb_cache_repl_mp;
  import cache_repl_pkg::*;

  localparam int unsigned NL   = 2;
  localparam int unsigned LSB  = 4;
  localparam int unsigned WSW  = 2;
  localparam int          SETS = 16;
  localparam int          WAYS = 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst, stall, flush, rv;
  logic [NL-1:0]                 lv;
  logic [NL-1:0][LSB-1:0]        ll;
  logic [NL-1:0][WSW-1:0]        lw;
  logic [LSB-1:0]                rl;
  logic                          done_f, done_p, done_r;

  cache_repl_mp_if #(.NumLookups(NL), .Lsb(LSB), .Wsw(WSW)) if_f ();
  cache_repl_mp_if #(.NumLookups(NL), .Lsb(LSB), .Wsw(WSW)) if_p ();
  cache_repl_mp_if #(.NumLookups(NL), .Lsb(LSB), .Wsw(WSW)) if_r ();

  assign if_f.lookup_valid = lv;
  assign if_f.lookup_line  = ll;
  assign if_f.lookup_way   = lw;
  assign if_f.repl_valid   = rv;
  assign if_f.repl_line    = rl;
  assign if_p.lookup_valid = lv;
  assign if_p.lookup_line  = ll;
  assign if_p.lookup_way   = lw;
  assign if_p.repl_valid   = rv;
  assign if_p.repl_line    = rl;
  assign if_r.lookup_valid = lv;
  assign if_r.lookup_line  = ll;
  assign if_r.lookup_way   = lw;
  assign if_r.repl_valid   = rv;
  assign if_r.repl_line    = rl;

  cache_repl_mp #(
    .CACHE_SIZE(4096), .LINE_SIZE(64), .NUM_BANKS(1), .NUM_WAYS(4), .NUM_LOOKUPS(2),
    .REPL_POLICY(FIFO)
  ) u_fifo (
    .clk(clk), .reset(rst), .stall(stall), .flush(flush), .init_done(done_f), .repl_if(if_f.slave)
  );

  cache_repl_mp #(
    .CACHE_SIZE(4096), .LINE_SIZE(64), .NUM_BANKS(1), .NUM_WAYS(4), .NUM_LOOKUPS(2),
    .REPL_POLICY(PLRU)
  ) u_plru (
    .clk(clk), .reset(rst), .stall(stall), .flush(flush), .init_done(done_p), .repl_if(if_p.slave)
  );

  cache_repl_mp #(
    .CACHE_SIZE(4096), .LINE_SIZE(64), .NUM_BANKS(1), .NUM_WAYS(4), .NUM_LOOKUPS(2),
    .REPL_POLICY(RROBIN)
  ) u_rr (
    .clk(clk), .reset(rst), .stall(stall), .flush(flush), .init_done(done_r), .repl_if(if_r.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model. Index 0 = FIFO instance, 1 = PLRU instance, 2 = RROBIN instance.
  bit m_ready;
  int m_swept;
  int m_rr;
  int m_fifo [SETS];
  bit m_left_lru [SETS];   // root: 1 -> victim in upper half {2,3}
  bit m_lo_pick1 [SETS];   // lower pair: 1 -> victim is way 1
  bit m_hi_pick3 [SETS];   // upper pair: 1 -> victim is way 3
  bit e_valid [3];
  int e_way [3];

  function automatic int plru_pick(int s);
    if (m_left_lru[s]) return m_hi_pick3[s] ? 3 : 2;
    return m_lo_pick1[s] ? 1 : 0;
  endfunction

  task automatic plru_touch(int s, int w);
    m_left_lru[s] = (w < 2);
    if (w < 2) m_lo_pick1[s] = (w == 0);
    else       m_hi_pick3[s] = (w == 2);
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_fifo[s] = 0; m_left_lru[s] = 0; m_lo_pick1[s] = 0; m_hi_pick3[s] = 0;
    end
  endtask

  task automatic model_edge();
    bit acc;
    int v [3];
    int s;
    s    = int'(rl);
    acc  = rv && m_ready && !stall;
    v[0] = m_fifo[s];
    v[1] = plru_pick(s);
    v[2] = m_rr;
    if (rst) begin
      m_ready = 0; m_swept = 0; m_rr = 0;
      for (int d = 0; d < 3; d++) begin e_valid[d] = 0; e_way[d] = 0; end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (!stall) begin
          e_valid[d] = acc;
          if (acc) e_way[d] = v[d];
        end
      end
      if (m_ready) begin
        if (!stall) m_rr = (m_rr + 1) % WAYS;
        for (int p = 0; p < NL; p++) if (lv[p]) plru_touch(int'(ll[p]), int'(lw[p]));
        if (acc) m_fifo[s] = (m_fifo[s] + 1) % WAYS;
        if (flush) begin m_ready = 0; m_swept = 0; end
      end else if (flush) begin
        m_swept = 0;
      end else begin
        m_swept++;
        if (m_swept == SETS) begin m_ready = 1; model_clear(); end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(string n, logic done, logic rdy, logic vld, logic [WSW-1:0] way, int d);
    chk({n, ".init_done"}, 32'(done), 32'(m_ready));
    chk({n, ".repl_ready"}, 32'(rdy), 32'(m_ready && !stall));
    chk({n, ".rsp_valid"}, 32'(vld), 32'(e_valid[d]));
    chk({n, ".repl_way"}, 32'(way), 32'(e_way[d]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk_dut("fifo", done_f, if_f.repl_ready, if_f.repl_rsp_valid, if_f.repl_way, 0);
    chk_dut("plru", done_p, if_p.repl_ready, if_p.repl_rsp_valid, if_p.repl_way, 1);
    chk_dut("rr", done_r, if_r.repl_ready, if_r.repl_rsp_valid, if_r.repl_way, 2);
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; rv = 0; lv = '0; ll = '0; lw = '0; rl = '0;
  endtask

  initial begin
    model_clear();
    m_ready = 0; m_swept = 0; m_rr = 0;
    for (int d = 0; d < 3; d++) begin e_valid[d] = 0; e_way[d] = 0; end
    idle();
    rst = 1;
    tick(); tick();
    chk("reset.init_done", 32'(done_p), 0);
    chk("reset.rsp_valid", 32'(if_p.repl_rsp_valid), 0);
    chk("reset.repl_way", 32'(if_p.repl_way), 0);

    rst = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("sweep.init_done", 32'(done_p), 32'(i == 16));
    end

    rv = 1; rl = 5;
    for (int k = 0; k < 3; k++) begin tick(); chk("fifo.l5", 32'(if_f.repl_way), 32'(k)); end
    rl = 6;
    tick(); chk("fifo.l6", 32'(if_f.repl_way), 0);
    rl = 11;
    for (int k = 0; k < 5; k++) begin tick(); chk("fifo.wrap", 32'(if_f.repl_way), 32'(k % 4)); end
    rv = 0; tick();

    rv = 1; rl = 3; tick(); chk("plru.l3a", 32'(if_p.repl_way), 0);
    rv = 0; lv = 2'b01; ll[0] = 3; lw[0] = 0; tick();
    lv = '0; rv = 1; tick(); chk("plru.l3b", 32'(if_p.repl_way), 2);
    rv = 0; lv = 2'b01; lw[0] = 2; tick();
    lv = '0; rv = 1; tick(); chk("plru.l3c", 32'(if_p.repl_way), 1);

    rv = 0; lv = 2'b11; ll[0] = 7; ll[1] = 7; lw[0] = 0; lw[1] = 3; tick();
    lv = '0; rv = 1; rl = 7; tick(); chk("plru.merge", 32'(if_p.repl_way), 1);

    rl = 9; lv = 2'b01; ll[0] = 9; lw[0] = 0; tick(); chk("plru.rbw0", 32'(if_p.repl_way), 0);
    lv = '0; tick(); chk("plru.rbw1", 32'(if_p.repl_way), 2);

    rl = 3; tick();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.valid", 32'(if_p.repl_rsp_valid), 1);
      chk("stall.way", 32'(if_p.repl_way), 1);
    end
    stall = 0; rv = 0; tick();

    flush = 1; tick(); chk("flush.init_done", 32'(done_p), 0);
    flush = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("flush.sweep", 32'(done_f), 32'(i == 16));
    end
    rv = 1; rl = 5; tick(); chk("flush.fifo_l5", 32'(if_f.repl_way), 0);
    rv = 0; tick();

    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 79) == 0);
      rv    = ($urandom_range(0, 2) != 0);
      rl    = LSB'($urandom_range(0, 3));
      lv    = NL'($urandom_range(0, 3));
      for (int p = 0; p < NL; p++) begin
        ll[p] = LSB'($urandom_range(0, 4));
        lw[p] = WSW'($urandom_range(0, 3));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
